// File: rtl/menu_multicampo.sv
// Multi-field menu selector: FIELDS independent option indices stepped by left/right arrows.
// Optional auto-repeat on a held arrow is built when MENU_AUTOREPEAT_EN is defined.
module menu_multicampo #(
    parameter int                                  FIELDS        = 6,
    parameter int                                  MAX_OPTS      = 16,
    // Field 0 occupies the least significant byte.
    parameter logic [FIELDS*8-1:0]                 OPTS          = {8'd4, 8'd2, 8'd4, 8'd3, 8'd16, 8'd3},
    parameter logic [FIELDS*$clog2(MAX_OPTS)-1:0]  DEFAULTS      = '0,
    parameter logic [FIELDS-1:0]                   WRAP_MASK     = 6'b001010,
    parameter int                                  HOLD_DELAY    = 50_000_000,
    parameter int                                  REPEAT_PERIOD = 10_000_000,
    localparam int                                 IDX_W         = $clog2(MAX_OPTS),
    localparam int                                 SEL_W         = (FIELDS > 1) ? $clog2(FIELDS) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      right_arrow_pressed,
    input  logic                      left_arrow_pressed,
    input  logic [SEL_W-1:0]          menu_sel,
    input  logic                      load_initial,
    input  logic                      lock,
    output logic [FIELDS*IDX_W-1:0]   valores,
    output logic [IDX_W-1:0]          valor_sel,
    output logic                      mudou,
    output logic                      no_limite
);

    logic [IDX_W-1:0] idx_q    [FIELDS];
    logic [IDX_W-1:0] idx_d    [FIELDS];
    logic [IDX_W-1:0] dflt     [FIELDS];
    logic [IDX_W-1:0] last_idx [FIELDS];
    logic [FIELDS-1:0] sel_hit;

    logic right_prev_q, right_prev_d;
    logic left_prev_q, left_prev_d;
    logic edge_r, edge_l;
    logic rep_r, rep_l;
    logic step_r, step_l;

    logic [IDX_W-1:0] valor_sel_q, valor_sel_d, valor_sel_rst;
    logic             mudou_q, mudou_d;
    logic             any_change;

    if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > HOLD_DELAY) begin : g_bad_timing
        $error("menu_multicampo: REPEAT_PERIOD=%0d must be in 1..HOLD_DELAY=%0d",
               REPEAT_PERIOD, HOLD_DELAY);
    end

    for (genvar gi = 0; gi < FIELDS; gi++) begin : g_field
        localparam int N = int'(OPTS[8*gi +: 8]);
        localparam int D = int'(DEFAULTS[IDX_W*gi +: IDX_W]);

        if (N < 2 || N > MAX_OPTS) begin : g_bad_opts
            $error("menu_multicampo: field %0d option count %0d out of range", gi, N);
        end
        if (D >= N) begin : g_bad_default
            $error("menu_multicampo: field %0d default %0d not below count %0d", gi, D, N);
        end

        assign last_idx[gi] = IDX_W'(N - 1);
        assign dflt[gi]     = (D >= N) ? IDX_W'(N - 1) : IDX_W'(D);
        assign sel_hit[gi]  = (int'(menu_sel) == gi);
        assign valores[IDX_W*gi +: IDX_W] = idx_q[gi];
    end

    // The edge registers follow the arrow level even during reset, so an arrow
    // held through reset is not mistaken for a fresh press afterwards.
    assign right_prev_d = right_arrow_pressed;
    assign left_prev_d  = left_arrow_pressed;
    assign edge_r       = right_arrow_pressed & ~right_prev_q;
    assign edge_l       = left_arrow_pressed & ~left_prev_q;

`ifdef MENU_AUTOREPEAT_EN
    localparam int CNT_W = $clog2(HOLD_DELAY + 1);

    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [SEL_W-1:0] rep_sel_q, rep_sel_d;
    logic             rep_fire;

    always_comb begin
        hold_cnt_d = '0;
        rep_fire   = 1'b0;
        rep_sel_d  = menu_sel;
        if ((right_arrow_pressed ^ left_arrow_pressed) && !lock && (menu_sel == rep_sel_q)) begin
            if (hold_cnt_q == CNT_W'(HOLD_DELAY)) begin
                rep_fire   = 1'b1;
                hold_cnt_d = CNT_W'(HOLD_DELAY - REPEAT_PERIOD + 1);
            end else begin
                hold_cnt_d = hold_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            hold_cnt_q <= '0;
            rep_sel_q  <= menu_sel;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            rep_sel_q  <= rep_sel_d;
        end
    end

    assign rep_r = rep_fire & right_arrow_pressed;
    assign rep_l = rep_fire & left_arrow_pressed;
`else
    assign rep_r = 1'b0;
    assign rep_l = 1'b0;
`endif

    always_comb begin
        step_r = (edge_r | rep_r) & ~(edge_l | rep_l);
        step_l = (edge_l | rep_l) & ~(edge_r | rep_r);
    end

    always_comb begin
        any_change    = 1'b0;
        valor_sel_d   = '0;
        valor_sel_rst = '0;
        no_limite     = 1'b0;
        for (int f = 0; f < FIELDS; f++) begin
            idx_d[f] = idx_q[f];
            if (load_initial) begin
                idx_d[f] = dflt[f];
            end else if (!lock && sel_hit[f]) begin
                if (step_r) begin
                    if (idx_q[f] != last_idx[f]) begin
                        idx_d[f] = idx_q[f] + IDX_W'(1);
                    end else if (WRAP_MASK[f]) begin
                        idx_d[f] = '0;
                    end
                end else if (step_l) begin
                    if (idx_q[f] != '0) begin
                        idx_d[f] = idx_q[f] - IDX_W'(1);
                    end else if (WRAP_MASK[f]) begin
                        idx_d[f] = last_idx[f];
                    end
                end
            end
            if (idx_d[f] != idx_q[f]) begin
                any_change = 1'b1;
            end
            if (sel_hit[f]) begin
                valor_sel_d   = idx_d[f];
                valor_sel_rst = dflt[f];
                if (!WRAP_MASK[f] && (idx_q[f] == '0 || idx_q[f] == last_idx[f])) begin
                    no_limite = 1'b1;
                end
            end
        end
        mudou_d = any_change;
    end

    always_ff @(posedge clock) begin
        right_prev_q <= right_prev_d;
        left_prev_q  <= left_prev_d;
        if (!reset) begin
            for (int f = 0; f < FIELDS; f++) begin
                idx_q[f] <= dflt[f];
            end
            valor_sel_q <= valor_sel_rst;
            mudou_q     <= 1'b0;
        end else begin
            for (int f = 0; f < FIELDS; f++) begin
                idx_q[f] <= idx_d[f];
            end
            valor_sel_q <= valor_sel_d;
            mudou_q     <= mudou_d;
        end
    end

    assign valor_sel = valor_sel_q;
    assign mudou     = mudou_q;

endmodule
